detect_event_monitor: RTL and testbench

- Sits directly downstream of the Moore sequence detector and consumes its one-cycle `detected` output.
- Counts detection events as a saturating lifetime total.
- Measures event rate over fixed windows opened by the first event and hands each window's count out over a valid/ready interface.
- Raises a sticky alarm when a window reaches a threshold.

---
 rtl/detect_event_monitor.sv | 151 +++++++++++++++
 tb/tb_detect_event_monitor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : detect_event_monitor
// Description : Counts edge events from a sequence detector, measures per-
//               window event rate with a valid/ready hand-off, sticky alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module detect_event_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             detected,
    input  logic             en,
    input  logic             clear,
    input  logic             alarm_ack,
    input  logic             rate_ready,
    output logic [CNT_W-1:0] total_cnt,
    output logic             alarm,
    output logic             rate_valid,
    output logic [CNT_W-1:0] rate_data,
    output logic             overrun,
    output logic             busy
);

    localparam int TMR_W = $clog2(WINDOW);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_OPEN   = 2'd1;
    localparam logic [1:0] c_REPORT = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_THRESH   = CNT_W'(THRESH);
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(WINDOW - 1);

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic             prev_det_q;
    logic             alarm_q, alarm_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             w_event;
    logic             w_alarm_set;
    logic             w_handshake;
    logic [CNT_W-1:0] w_win_inc;

    // A held level counts once: only the rising edge of detected is an event.
    assign w_event     = detected & ~prev_det_q & en;
    assign w_handshake = valid_q & rate_ready;
    assign w_win_inc   = (w_event && (win_q != c_CNT_MAX)) ? win_q + CNT_W'(1) : win_q;

    always_comb begin
        total_d = total_q;
        if (clear) begin
            total_d = CNT_W'(w_event);
        end else if (w_event && (total_q != c_CNT_MAX)) begin
            total_d = total_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        win_d       = win_q;
        w_alarm_set = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_event) begin
                    state_d     = c_OPEN;
                    win_d       = CNT_W'(1);
                    timer_d     = TMR_W'(1);
                    w_alarm_set = (c_THRESH == CNT_W'(1));
                end
            end
            c_OPEN: begin
                win_d = w_win_inc;
                // Old count check keeps a saturated count from re-arming the alarm.
                w_alarm_set = w_event && (w_win_inc == c_THRESH) && (win_q != c_THRESH);
                if (timer_q == c_TMR_LAST) begin
                    state_d = c_REPORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            c_REPORT: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // win_q holds the closed window's final count throughout REPORT.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (state_q == c_REPORT) begin
            if (!valid_q || w_handshake) begin
                data_d  = win_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (w_handshake) begin
            valid_d = 1'b0;
        end
    end

    assign alarm_d = w_alarm_set | (alarm_q & ~alarm_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            timer_q    <= '0;
            win_q      <= '0;
            total_q    <= '0;
            data_q     <= '0;
            prev_det_q <= 1'b0;
            alarm_q    <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            win_q      <= win_d;
            total_q    <= total_d;
            data_q     <= data_d;
            prev_det_q <= detected;
            alarm_q    <= alarm_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign total_cnt  = total_q;
    assign alarm      = alarm_q;
    assign rate_valid = valid_q;
    assign rate_data  = data_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == c_OPEN);

endmodule
`default_nettype wire

// File: tb/tb_detect_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_detect_event_monitor
// Description : Scenario tasks plus randomized run against a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detect_event_monitor;

    localparam int CW   = 4;
    localparam int WIN  = 8;
    localparam int TH   = 3;
    localparam int MAXV = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          detected = 1'b0;
    logic          en = 1'b1;
    logic          clear = 1'b0;
    logic          alarm_ack = 1'b0;
    logic          rate_ready = 1'b1;
    logic [CW-1:0] total_cnt;
    logic          alarm;
    logic          rate_valid;
    logic [CW-1:0] rate_data;
    logic          overrun;
    logic          busy;

    int n_checks = 0;
    int n_bad    = 0;

    // Model: a window is identified by the cycle it opened in.
    int            cyc      = 0;
    int            m_wstart = -1;
    int            m_wcnt   = 0;
    bit            m_done   = 1'b0;
    bit            m_prev   = 1'b0;
    logic [CW-1:0] m_total  = '0;
    logic [CW-1:0] m_data   = '0;
    logic          m_valid  = 1'b0;
    logic          m_alarm  = 1'b0;
    logic          m_ovr    = 1'b0;
    logic          m_busy   = 1'b0;

    detect_event_monitor #(.CNT_W(CW), .WINDOW(WIN), .THRESH(TH)) dut (
        .clk        (clk),
        .rst        (rst),
        .detected   (detected),
        .en         (en),
        .clear      (clear),
        .alarm_ack  (alarm_ack),
        .rate_ready (rate_ready),
        .total_cnt  (total_cnt),
        .alarm      (alarm),
        .rate_valid (rate_valid),
        .rate_data  (rate_data),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input bit d, input bit e, input bit c, input bit a,
                              input bit rdy, input bit r);
        bit ev, hs, set, rep;
        if (r) begin
            m_wstart = -1; m_wcnt = 0; m_done = 1'b0; m_prev = 1'b0;
            m_total = '0; m_data = '0; m_valid = 1'b0; m_alarm = 1'b0;
            m_ovr = 1'b0; m_busy = 1'b0;
        end else begin
            ev  = d && !m_prev && e;
            hs  = m_valid && rdy;
            set = 1'b0;
            rep = 1'b0;
            if (c)                          m_total = ev ? 4'd1 : 4'd0;
            else if (ev && m_total != MAXV) m_total = m_total + 4'd1;
            if (m_wstart >= 0 && cyc <= m_wstart + WIN - 1) begin
                if (ev) begin
                    if (m_wcnt < MAXV) m_wcnt++;
                    if (m_wcnt == TH && !m_done) begin set = 1'b1; m_done = 1'b1; end
                end
            end else if (m_wstart >= 0 && cyc == m_wstart + WIN) begin
                rep = 1'b1;
                m_wstart = -1;
            end else if (ev) begin
                m_wstart = cyc;
                m_wcnt   = 1;
                m_done   = (TH == 1);
                set      = m_done;
            end
            if (rep) begin
                if (!m_valid || hs) begin
                    m_data  = CW'(m_wcnt);
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
            m_alarm = set || (m_alarm && !a);
            m_prev  = d;
            m_busy  = (m_wstart >= 0) && (cyc <= m_wstart + WIN - 2);
        end
        cyc++;
    endtask

    task automatic step(input bit d, input bit e, input bit c, input bit a,
                        input bit rdy, input bit r);
        detected = d; en = e; clear = c; alarm_ack = a; rate_ready = rdy; rst = r;
        @(posedge clk);
        model_edge(d, e, c, a, rdy, r);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(i[0] == 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if ({total_cnt, alarm, rate_valid, rate_data, overrun, busy} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got total=%0d alarm=%b valid=%b data=%0d ovr=%b busy=%b, want all 0",
                         total_cnt, alarm, rate_valid, rate_data, overrun, busy);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (total_cnt !== 4'd0 || rate_valid !== 1'b0 || alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got total=%0d valid=%b alarm=%b, want 0 0 0",
                     total_cnt, rate_valid, alarm);
        end
    endtask

    task automatic test_window();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(i == 0 || i == 2 || i == 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 0 || i == 2 || i == 4) begin
                n_checks++;
                if (total_cnt !== CW'(i / 2 + 1)) begin
                    n_bad++;
                    $display("FAIL win_total step %0d: got %0d want %0d", i, total_cnt, i / 2 + 1);
                end
            end
            n_checks++;
            if (busy !== (i <= 6)) begin
                n_bad++;
                $display("FAIL win_busy step %0d: got %b want %b", i, busy, i <= 6);
            end
            n_checks++;
            if (alarm !== (i >= 4)) begin
                n_bad++;
                $display("FAIL win_alarm step %0d: got %b want %b", i, alarm, i >= 4);
            end
            n_checks++;
            if (rate_valid !== (i == 8)) begin
                n_bad++;
                $display("FAIL win_valid step %0d: got %b want %b", i, rate_valid, i == 8);
            end
            if (i == 8) begin
                n_checks++;
                if (rate_data !== 4'd3) begin
                    n_bad++;
                    $display("FAIL win_data: got %0d want 3", rate_data);
                end
            end
        end
    endtask

    task automatic test_hold_en();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(i < 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 8) begin
                n_checks++;
                if (rate_valid !== 1'b1 || rate_data !== 4'd1) begin
                    n_bad++;
                    $display("FAIL hold_report: got valid=%b data=%0d want 1 1", rate_valid, rate_data);
                end
            end
        end
        n_checks++;
        if (total_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL hold_total: got %0d want 1", total_cnt);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (total_cnt !== 4'd1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL en_low: got total=%0d busy=%b want 1 0", total_cnt, busy);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(i == 0 || i == 2 || i == 9 || i == 11 || i == 13 || i == 15,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 8 || i == 17) begin
                n_checks++;
                if (rate_valid !== 1'b1 || rate_data !== 4'd2 || overrun !== (i == 17)) begin
                    n_bad++;
                    $display("FAIL ovr_step %0d: got valid=%b data=%0d ovr=%b want 1 2 %b",
                             i, rate_valid, rate_data, overrun, i == 17);
                end
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (rate_valid !== 1'b0 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_drain: got valid=%b ovr=%b want 0 1", rate_valid, overrun);
        end
    endtask

    task automatic test_saturate_clear();
        do_reset();
        for (int i = 0; i < 40; i++) step(i % 2 == 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (total_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_total: got %0d want 15", total_cnt);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (total_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL clear_with_event: got %0d want 1", total_cnt);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (total_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL clear_alone: got %0d want 0", total_cnt);
        end
    endtask

    task automatic test_ack();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(i == 0 || i == 2 || i == 4 || i == 9 || i == 11 || i == 13,
                 1'b1, 1'b0, i == 5 || i == 13, 1'b1, 1'b0);
            if (i == 5) begin
                n_checks++;
                if (alarm !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ack_clear: got %b want 0", alarm);
                end
            end
        end
        n_checks++;
        if (alarm !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_vs_set: got %b want 1", alarm);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(i == 0 || i == 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || total_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL midrst_state: got busy=%b total=%0d want 0 0", busy, total_cnt);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (rate_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_valid step %0d: got %b want 0", i, rate_valid);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
            n_checks++;
            if (total_cnt !== m_total || alarm !== m_alarm || busy !== m_busy ||
                rate_valid !== m_valid || overrun !== m_ovr ||
                (m_valid && rate_data !== m_data)) begin
                n_bad++;
                $display("FAIL rand step %0d: got t=%0d a=%b b=%b v=%b d=%0d o=%b want t=%0d a=%b b=%b v=%b d=%0d o=%b",
                         i, total_cnt, alarm, busy, rate_valid, rate_data, overrun,
                         m_total, m_alarm, m_busy, m_valid, m_data, m_ovr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_hold_en();
        test_overrun();
        test_saturate_clear();
        test_ack();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
